reg_share_arb: RTL and testbench

Round-robin arbiter that shares one DW-bit holding register among NREQ requesters. Each requester raises a level request, receives a registered one-hot grant, and writes the shared register on every cycle it holds the grant with its request high. The block sits in front of the shared register bank and is the only writer to it. An optional hold limit forces rotation so that no requester can monopolise the register.

---
 rtl/reg_share_arb.sv | 120 ++++++++++++
 tb/tb_reg_share_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter that owns a single DW-bit shared register.
//   Ports: clk/rst (async, active-high); req/wr_data per requester in; gnt (one-hot),
//   owner, q, wr_pulse out -- all outputs registered.
// Optional macro REG_SHARE_ARB_TIMEOUT_EN adds a per-grant hold counter that forces
// rotation after MAX_HOLD writes whenever another requester is waiting.
module reg_share_arb #(
  parameter int NREQ     = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       wr_data,
  output logic [NREQ-1:0]          gnt,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic [DW-1:0]            q,
  output logic                     wr_pulse
);

  localparam int IW = $clog2(NREQ);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [0:0]      state;
  logic [IW-1:0]   last;

  logic [NREQ-1:0] one;
  logic [NREQ-1:0] own_mask;
  logic [NREQ-1:0] mask;
  logic            own_req;
  logic [DW-1:0]   own_data;
  logic            win_vld;
  logic [IW-1:0]   win_idx;
  logic [NREQ-1:0] win_oh;
  logic            rotate;
  logic            take;

  assign one      = {{(NREQ-1){1'b0}}, 1'b1};
  assign own_mask = one << owner;
  assign own_req  = req[owner];
  assign own_data = wr_data[owner*DW +: DW];

  // While busy the current owner is excluded from the candidate set: on a release
  // its bit is already low, and on a forced rotation it must not win again.
  assign mask = (state == S_BUSY) ? (req & ~own_mask) : req;

  // Search last+1, last+2, ... wrapping; walking k downward lets the nearest
  // candidate overwrite any farther one.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (mask[idx]) begin
        win_vld = 1'b1;
        win_idx = idx[IW-1:0];
      end
    end
  end

  assign win_oh = one << win_idx;

`ifdef REG_SHARE_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [7:0] hold_cnt;
  logic [7:0] hold_nxt;

  // Saturates at HOLD_MAX so a lone owner keeps rotating eligibility pending.
  assign hold_nxt = (hold_cnt >= HOLD_MAX) ? HOLD_MAX : hold_cnt + 8'd1;
  assign rotate   = (hold_nxt == HOLD_MAX) && win_vld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= 8'd0;
    end else if (take) begin
      hold_cnt <= 8'd0;
    end else if (state == S_BUSY && own_req) begin
      hold_cnt <= hold_nxt;
    end
  end
`else
  assign rotate = 1'b0;
`endif

  // A new grant is issued from idle, on release, or on a forced rotation.
  assign take = win_vld && ((state == S_IDLE) || !own_req || rotate);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      gnt      <= '0;
      owner    <= '0;
      last     <= IW'(NREQ - 1);
      q        <= '0;
      wr_pulse <= 1'b0;
    end else begin
      wr_pulse <= 1'b0;
      if (state == S_BUSY && own_req) begin
        q        <= own_data;
        wr_pulse <= 1'b1;
      end
      if (take) begin
        gnt   <= win_oh;
        owner <= win_idx;
        last  <= win_idx;
        state <= S_BUSY;
      end else if (state == S_BUSY && !own_req) begin
        // Release with nobody waiting: owner keeps its last value.
        gnt   <= '0;
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_reg_share_arb.sv
module tb_reg_share_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] wr_data = '0;
  logic [NREQ-1:0]   gnt;
  logic [1:0]        owner;
  logic [DW-1:0]     q;
  logic              wr_pulse;

  int tests = 0;
  int fails = 0;
  logic [DW-1:0] exp_q[$];

  reg_share_arb #(.NREQ(NREQ), .DW(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .wr_data(wr_data),
    .gnt(gnt), .owner(owner), .q(q), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  // Scoreboard: every observed write must match the oldest expected value.
  always @(posedge clk) begin
    #1;
    if (wr_pulse === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected_write: q=%h, no write expected", q);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (q !== e) begin
          fails++;
          $display("FAIL sb_write_data: q=%h expected %h", q, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] v);
    wr_data[i*DW +: DW] = v;
  endtask

  task automatic do_reset();
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_gnt(input string name, input logic [NREQ-1:0] e);
    tests++;
    if (gnt !== e) begin
      fails++;
      $display("FAIL %s: gnt=%b expected %b", name, gnt, e);
    end
  endtask

  task automatic test_reset();
    tests++;
    if (gnt !== 4'b0000 || owner !== 2'd0 || q !== 8'h00 || wr_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: gnt=%b owner=%0d q=%h wr_pulse=%b expected 0000/0/00/0",
               gnt, owner, q, wr_pulse);
    end
    @(negedge clk);
    rst = 1'b0;
    set_data(1, 8'h5A);
    req = 4'b0010;
    tick();
    chk_gnt("reset_first_grant", 4'b0010);
    exp_q.push_back(8'h5A);
    tick();
    tests++;
    if (wr_pulse !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_write: wr_pulse=%b expected 1", wr_pulse);
    end
    // Mid-cycle reset while granted and writing.
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (gnt !== 4'b0000 || q !== 8'h00 || wr_pulse !== 1'b0 || owner !== 2'd0) begin
      fails++;
      $display("FAIL reset_async: gnt=%b q=%h wr_pulse=%b owner=%0d expected 0000/00/0/0",
               gnt, q, wr_pulse, owner);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk_gnt("reset_regrant", 4'b0010);
    tests++;
    if (owner !== 2'd1 || wr_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_regrant_owner: owner=%0d wr_pulse=%b expected 1/0", owner, wr_pulse);
    end
    req = '0;
    tick();
    chk_gnt("reset_release", 4'b0000);
  endtask

  task automatic test_single();
    set_data(2, 8'hA5);
    req = 4'b0100;
    tick();
    chk_gnt("single_grant", 4'b0100);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'hA5);
      tick();
      tests++;
      if (wr_pulse !== 1'b1 || q !== 8'hA5 || gnt !== 4'b0100) begin
        fails++;
        $display("FAIL single_write%0d: wr_pulse=%b q=%h gnt=%b expected 1/a5/0100",
                 i, wr_pulse, q, gnt);
      end
    end
    req = '0;
    tick();
    chk_gnt("single_drop", 4'b0000);
    tests++;
    if (wr_pulse !== 1'b0 || owner !== 2'd2) begin
      fails++;
      $display("FAIL single_drop_state: wr_pulse=%b owner=%0d expected 0/2", wr_pulse, owner);
    end
  endtask

  task automatic test_round_robin();
    int o;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_data(i, 8'hC0 + 8'(i));
    req = 4'b1111;
    tick();
    chk_gnt("rr_first", 4'b0001);
    o = 0;
    for (int k = 0; k < 4; k++) begin
      logic [NREQ-1:0] e;
      exp_q.push_back(8'hC0 + 8'(o));
      tick();
      tests++;
      if (wr_pulse !== 1'b1) begin
        fails++;
        $display("FAIL rr_write%0d: wr_pulse=%b expected 1", k, wr_pulse);
      end
      req[o] = 1'b0;
      tick();
      o = (o + 1) % NREQ;
      e = '0;
      e[o] = 1'b1;
      chk_gnt("rr_handover", e);
      tests++;
      if (wr_pulse !== 1'b0 || owner !== 2'(o)) begin
        fails++;
        $display("FAIL rr_handover_state%0d: wr_pulse=%b owner=%0d expected 0/%0d",
                 k, wr_pulse, owner, o);
      end
      req = 4'b1111;
    end
    req = '0;
    tick();
    chk_gnt("rr_end", 4'b0000);
  endtask

  task automatic test_handover();
    do_reset();
    set_data(0, 8'h11);
    set_data(3, 8'h33);
    req = 4'b1001;
    tick();
    chk_gnt("ho_grant0", 4'b0001);
    exp_q.push_back(8'h11);
    tick();
    tests++;
    if (q !== 8'h11 || wr_pulse !== 1'b1) begin
      fails++;
      $display("FAIL ho_q11: q=%h wr_pulse=%b expected 11/1", q, wr_pulse);
    end
    req[0] = 1'b0;
    tick();
    chk_gnt("ho_grant3", 4'b1000);
    tests++;
    if (wr_pulse !== 1'b0 || q !== 8'h11) begin
      fails++;
      $display("FAIL ho_gap: wr_pulse=%b q=%h expected 0/11", wr_pulse, q);
    end
    exp_q.push_back(8'h33);
    tick();
    tests++;
    if (q !== 8'h33 || wr_pulse !== 1'b1) begin
      fails++;
      $display("FAIL ho_q33: q=%h wr_pulse=%b expected 33/1", q, wr_pulse);
    end
    req = '0;
    tick();
    chk_gnt("ho_end", 4'b0000);
  endtask

  task automatic test_timeout();
    do_reset();
    set_data(1, 8'h71);
    set_data(2, 8'h72);
    req = 4'b0010;
    tick();
    chk_gnt("to_grant1", 4'b0010);
    req = 4'b0110;
`ifdef REG_SHARE_ARB_TIMEOUT_EN
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'h71);
      tick();
      chk_gnt("to_hold", (i == 4) ? 4'b0100 : 4'b0010);
    end
    exp_q.push_back(8'h72);
    tick();
    req = '0;
    tick();
    chk_gnt("to_end", 4'b0000);
    // Late waiter: counter saturated, rotation at the first write edge it is seen.
    do_reset();
    req = 4'b0010;
    tick();
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'h71);
      tick();
      chk_gnt("to_sat_hold", 4'b0010);
    end
    req = 4'b0110;
    exp_q.push_back(8'h71);
    tick();
    chk_gnt("to_late_rotate", 4'b0100);
`else
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(8'h71);
      tick();
      chk_gnt("to_keep", 4'b0010);
    end
`endif
    req = '0;
    tick();
    chk_gnt("to_release", 4'b0000);
  endtask

  task automatic test_stale();
    do_reset();
    set_data(0, 8'h0A);
    set_data(3, 8'hEE);
    req = 4'b0001;
    tick();
    chk_gnt("stale_grant0", 4'b0001);
    exp_q.push_back(8'h0A);
    req = 4'b1001;
    tick();
    chk_gnt("stale_hold_a", 4'b0001);
    req = 4'b0001;
    exp_q.push_back(8'h0A);
    tick();
    chk_gnt("stale_hold_b", 4'b0001);
    req = '0;
    tick();
    chk_gnt("stale_release", 4'b0000);
    tick();
    chk_gnt("stale_no_late_grant", 4'b0000);
    tests++;
    if (q !== 8'h0A) begin
      fails++;
      $display("FAIL stale_q: q=%h expected 0a", q);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_single();
    test_round_robin();
    test_handover();
    test_timeout();
    test_stale();
    tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_pending: %0d expected writes never seen, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
